color_dominance_classifier: RTL and testbench

- Successor to the RGB111 dominant-colour detector in the camera datapath.
- Scans one captured frame from the frame-buffer read port, one pixel per clock, and accumulates per-channel intensity sums.
- Reports the dominant channel (red, green, blue or none) behind a start/done handshake.
- Pixel format, frame size, memory read latency and decision margin are all parametrised.

---
 rtl/color_pkg.sv | 32 +++
 rtl/color_align.sv | 41 ++++
 rtl/color_dominance_classifier.sv | 181 ++++++++++++++++++
 tb/tb_color_dominance_classifier.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_pkg
// Description : Shared types and constants for the dominant-colour classifier
//               and the display path (result encoding, FSM states, alignment
//               width).
// Revision    : 1.0 - initial release
// ============================================================================
package color_pkg;

  // Width every colour component is left-aligned to before use.
  localparam int ALIGN_W = 8;

  // Classification result, as presented on the result port.
  typedef enum logic [1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_e;

  // Frame-scan controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage : color_pkg
`default_nettype wire

// File: rtl/color_align.sv
`default_nettype none
// ============================================================================
// Module      : color_align
// Description : Combinational unpack of one {R,G,B} pixel and left-alignment
//               of each component to ALIGN_W bits (LSBs zero-filled), so that
//               channels of different widths share a common scale.
// Ports       : pix      - packed pixel, R in the MSBs
//               r8/g8/b8 - left-aligned components
// Revision    : 1.0 - initial release
// ============================================================================
module color_align
  import color_pkg::*;
#(
  parameter int R_W = 3,
  parameter int G_W = 3,
  parameter int B_W = 2
) (
  input  logic [R_W+G_W+B_W-1:0] pix,
  output logic [ALIGN_W-1:0]     r8,
  output logic [ALIGN_W-1:0]     g8,
  output logic [ALIGN_W-1:0]     b8
);

  localparam int c_pw = R_W + G_W + B_W;

  logic [R_W-1:0] w_r;
  logic [G_W-1:0] w_g;
  logic [B_W-1:0] w_b;

  assign w_r = pix[c_pw-1 -: R_W];
  assign w_g = pix[B_W+G_W-1 -: G_W];
  assign w_b = pix[B_W-1:0];

  // Shifting the zero-extended field keeps an 8-bit component legal
  // (shift of zero) without a zero-width replication.
  assign r8 = ALIGN_W'(w_r) << (ALIGN_W - R_W);
  assign g8 = ALIGN_W'(w_g) << (ALIGN_W - G_W);
  assign b8 = ALIGN_W'(w_b) << (ALIGN_W - B_W);

endmodule : color_align
`default_nettype wire

// File: rtl/color_dominance_classifier.sv
`default_nettype none
// ============================================================================
// Module      : color_dominance_classifier
// Description : Scans one frame from the frame-buffer read port (one pixel per
//               clock), accumulates left-aligned per-channel sums and reports
//               the dominant channel behind a start/done handshake.
// Ports       : P_clk    - clock, rising edge
//               rst_n    - synchronous active-low reset
//               start    - one-cycle classify request (sampled in IDLE only)
//               data     - pixel {R,G,B} returned RD_LAT cycles after addr
//               addr     - frame-buffer read address
//               read_en  - high while addresses are issued
//               busy     - high in READ, DRAIN and DECIDE
//               done     - one-cycle pulse when result is valid
//               result   - 0 NONE, 1 RED, 2 GREEN, 3 BLUE
// Options     : COLOR_DARK_SKIP_EN - when defined, pixels whose aligned R, G
//               and B are all below DARK_TH are excluded from the sums.
// Revision    : 1.0 - initial release
// ============================================================================
module color_dominance_classifier
  import color_pkg::*;
#(
  parameter int AW     = 15,
  parameter int NPIX   = 25344,
  parameter int R_W    = 3,
  parameter int G_W    = 3,
  parameter int B_W    = 2,
  parameter int RD_LAT = 1,
  parameter int MARGIN = 0
`ifdef COLOR_DARK_SKIP_EN
  ,
  parameter logic [7:0] DARK_TH = 8'd32
`endif
) (
  input  logic                   P_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [R_W+G_W+B_W-1:0] data,
  output logic [AW-1:0]          addr,
  output logic                   read_en,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             result
);

  // NPIX <= 2^AW and components <= 255 keep every sum below 2^(AW+8).
  localparam int c_sw = AW + ALIGN_W;
  localparam logic [c_sw:0] c_margin = (c_sw+1)'(MARGIN);

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_drain;
  logic [RD_LAT-1:0] r_vld;
  logic [c_sw-1:0] r_sum_r, r_sum_g, r_sum_b;
  color_e          r_result, w_winner;

  logic [ALIGN_W-1:0] w_r8, w_g8, w_b8;
  logic               w_last_addr, w_acc_en;

  color_align #(.R_W(R_W), .G_W(G_W), .B_W(B_W)) u_align (
    .pix (data),
    .r8  (w_r8),
    .g8  (w_g8),
    .b8  (w_b8)
  );

  assign w_last_addr = (r_addr == AW'(NPIX - 1));

`ifdef COLOR_DARK_SKIP_EN
  assign w_acc_en = r_vld[RD_LAT-1] &&
                    !((w_r8 < DARK_TH) && (w_g8 < DARK_TH) && (w_b8 < DARK_TH));
`else
  assign w_acc_en = r_vld[RD_LAT-1];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge P_clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    read_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_READ;
      ST_READ: begin
        read_en = 1'b1;
        busy    = 1'b1;
        if (w_last_addr) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain == 3'(RD_LAT - 1)) w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- valid pipeline ----------------
  // Bit k is set when the address issued k+1 cycles ago was valid; the top
  // bit lines up with the pixel currently on data.
  generate
    if (RD_LAT == 1) begin : g_vld_single
      always_ff @(posedge P_clk) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= read_en;
      end
    end else begin : g_vld_multi
      always_ff @(posedge P_clk) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= {r_vld[RD_LAT-2:0], read_en};
      end
    end
  endgenerate

  // ---------------- address, drain count, sums, result ----------------
  always_ff @(posedge P_clk) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_drain  <= '0;
      r_sum_r  <= '0;
      r_sum_g  <= '0;
      r_sum_b  <= '0;
      r_result <= COLOR_NONE;
    end else begin
      case (r_state)
        ST_IDLE:   r_addr <= '0;
        ST_READ: begin
          r_addr  <= w_last_addr ? '0 : r_addr + 1'b1;
          r_drain <= '0;
        end
        ST_DRAIN:  r_drain <= r_drain + 3'd1;
        ST_DECIDE: r_result <= w_winner;
        default:   r_addr <= '0;
      endcase

      if (r_state == ST_IDLE && start) begin
        r_sum_r <= '0;
        r_sum_g <= '0;
        r_sum_b <= '0;
      end else if (w_acc_en) begin
        r_sum_r <= r_sum_r + c_sw'(w_r8);
        r_sum_g <= r_sum_g + c_sw'(w_g8);
        r_sum_b <= r_sum_b + c_sw'(w_b8);
      end
    end
  end

  // ---------------- decision ----------------
  // One extra bit so adding the margin can never wrap.
  logic [c_sw:0] w_xr, w_xg, w_xb, w_mr, w_mg, w_mb;

  always_comb begin
    w_xr = {1'b0, r_sum_r};
    w_xg = {1'b0, r_sum_g};
    w_xb = {1'b0, r_sum_b};
    w_mr = w_xr + c_margin;
    w_mg = w_xg + c_margin;
    w_mb = w_xb + c_margin;
    w_winner = COLOR_NONE;
    if (w_xr > w_mg && w_xr > w_mb)      w_winner = COLOR_RED;
    else if (w_xg > w_mr && w_xg > w_mb) w_winner = COLOR_GREEN;
    else if (w_xb > w_mr && w_xb > w_mg) w_winner = COLOR_BLUE;
  end

  assign addr   = r_addr;
  assign result = r_result;

endmodule : color_dominance_classifier
`default_nettype wire

// File: tb/tb_color_dominance_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_dominance_classifier
// Description : Self-checking bench for color_dominance_classifier. Two
//               instances (MARGIN 0 and 300) share one frame-buffer model
//               with one cycle of read latency. Directed and random frames
//               are compared against a per-pixel arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_dominance_classifier;

  localparam int AW     = 4;
  localparam int NPIX   = 16;
  localparam int R_W    = 3;
  localparam int G_W    = 3;
  localparam int B_W    = 2;
  localparam int RD_LAT = 1;
  localparam int M_A    = 0;
  localparam int M_B    = 300;
  localparam int LAT    = NPIX + RD_LAT + 2;

  logic P_clk = 1'b0;
  always #5 P_clk = ~P_clk;

  logic          rst_n, start;
  logic [7:0]    data;
  logic [AW-1:0] addr_a, addr_b;
  logic          ren_a, ren_b, busy_a, busy_b, done_a, done_b;
  logic [1:0]    res_a, res_b;

  color_dominance_classifier #(
    .AW(AW), .NPIX(NPIX), .R_W(R_W), .G_W(G_W), .B_W(B_W),
    .RD_LAT(RD_LAT), .MARGIN(M_A)
  ) dut_a (
    .P_clk(P_clk), .rst_n(rst_n), .start(start), .data(data),
    .addr(addr_a), .read_en(ren_a), .busy(busy_a), .done(done_a),
    .result(res_a)
  );

  color_dominance_classifier #(
    .AW(AW), .NPIX(NPIX), .R_W(R_W), .G_W(G_W), .B_W(B_W),
    .RD_LAT(RD_LAT), .MARGIN(M_B)
  ) dut_b (
    .P_clk(P_clk), .rst_n(rst_n), .start(start), .data(data),
    .addr(addr_b), .read_en(ren_b), .busy(busy_b), .done(done_b),
    .result(res_b)
  );

  // Frame-buffer model: data follows addr by one clock.
  logic [7:0] mem [NPIX];
  always @(posedge P_clk) data <= mem[addr_a];

  // Address-coverage and done-pulse monitors.
  int hits [NPIX];
  int ren_cycles;
  int done_cnt;
  always @(negedge P_clk) begin
    if (ren_a) begin
      hits[addr_a] = hits[addr_a] + 1;
      ren_cycles   = ren_cycles + 1;
    end
    if (done_a) done_cnt = done_cnt + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: scale each field to 0..255 by its bit weight, sum, then apply
  // the "beats both others by more than the margin" rule.
  function automatic int ref_result(input int margin);
    int sr, sg, sb, r, g, b, p;
    sr = 0; sg = 0; sb = 0;
    for (int i = 0; i < NPIX; i++) begin
      p = int'(mem[i]);
      r = ((p / 32) % 8) * 32;
      g = ((p / 4) % 8) * 32;
      b = (p % 4) * 64;
`ifdef COLOR_DARK_SKIP_EN
      if (r < 32 && g < 32 && b < 32) continue;
`endif
      sr += r; sg += g; sb += b;
    end
    if (sr > sg + margin && sr > sb + margin) return 1;
    if (sg > sr + margin && sg > sb + margin) return 2;
    if (sb > sr + margin && sb > sg + margin) return 3;
    return 0;
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < NPIX; i++) hits[i] = 0;
    ren_cycles = 0;
    done_cnt   = 0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) mem[i] = v;
  endtask

  // Issue start and check one complete frame. poke=1 also pulses start
  // mid-READ and in the DONE cycle; both must be ignored.
  task automatic run_frame(input string tag, input bit poke);
    int cyc, exp_a, exp_b, bad;
    bit seen;
    exp_a = ref_result(M_A);
    exp_b = ref_result(M_B);
    clear_mon();
    start = 1'b1;
    @(negedge P_clk);
    start = 1'b0;
    cyc   = 1;
    chk({tag, "_busy"}, int'(busy_a), 1);
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (done_a) seen = 1'b1;
      else begin
        start = (poke && cyc == 5);
        @(negedge P_clk);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, cyc, LAT);
    chk({tag, "_res_m0"}, int'(res_a), exp_a);
    chk({tag, "_res_m300"}, int'(res_b), exp_b);
    chk({tag, "_done_b"}, int'(done_b), 1);
    start = poke;  // start coincident with done
    @(negedge P_clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, int'(done_a), 0);
    @(negedge P_clk);
    @(negedge P_clk);
    chk({tag, "_idle_busy"}, int'(busy_a), 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_ren_cycles"}, ren_cycles, NPIX);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (hits[i] != 1) bad++;
    chk({tag, "_addr_cover"}, bad, 0);
    chk({tag, "_res_held"}, int'(res_a), exp_a);
  endtask

  initial begin
    int k, base;
    rst_n = 1'b0;
    start = 1'b0;
    fill(8'h00);
    repeat (3) @(negedge P_clk);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_ren", int'(ren_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_result", int'(res_a), 0);
    rst_n = 1'b1;
    @(negedge P_clk);

    fill(8'hE0); run_frame("red", 1'b0);
    fill(8'h03); run_frame("blue", 1'b0);
    fill(8'h1C); run_frame("green", 1'b0);
    for (int i = 0; i < NPIX; i++) mem[i] = (i < 8) ? 8'hE0 : 8'h1C;
    run_frame("tie", 1'b0);
    mem[15] = 8'h00;
    run_frame("margin", 1'b0);
    fill(8'h20); mem[15] = 8'h1C;
    run_frame("dark", 1'b0);
    fill(8'h40); mem[15] = 8'h00;
    run_frame("dim_red", 1'b0);
    fill(8'h00); run_frame("zero", 1'b1);

    // Reset in the middle of READ: frame abandoned, no done.
    fill(8'h1C);
    clear_mon();
    start = 1'b1;
    @(negedge P_clk);
    start = 1'b0;
    k = 0;
    while (int'(addr_a) != 7 && k < 50) begin @(negedge P_clk); k++; end
    chk("mid_addr7", int'(addr_a), 7);
    rst_n = 1'b0;
    @(negedge P_clk);
    chk("mid_rst_addr", int'(addr_a), 0);
    chk("mid_rst_ren", int'(ren_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_result", int'(res_a), 0);
    rst_n = 1'b1;
    repeat (25) @(negedge P_clk);
    chk("mid_no_done", done_cnt, 0);
    run_frame("after_rst", 1'b0);

    // Random frames: a dominant base colour plus random noise pixels.
    for (int f = 0; f < 16; f++) begin
      base = $urandom_range(0, 255);
      for (int i = 0; i < NPIX; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(base);
      run_frame($sformatf("rnd%0d", f), f[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_color_dominance_classifier
`default_nettype wire
